// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch stage
package fetch_pkg;
  localparam logic [2:0] FUNCT3_WORD = 3'b010;
  localparam logic [31:0] INST_STOP = 32'h0;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
  typedef struct packed {
    logic vld;
    logic ep;
    logic [31:0] pc;
  } trk_stage_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction buffer with flush; head reads as zero when empty
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  fetch_entry_t               entry_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output fetch_entry_t               head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push_i && !flush_i && (cnt_q != CW'(DEPTH));
    do_pop = pop_i && (cnt_q != '0);
    wr_d = flush_i ? '0 : wr_q + AW'(do_push);
    rd_d = flush_i ? '0 : rd_q + AW'(do_pop);
    cnt_d = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= entry_i;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign count_o = cnt_q;
  assign head_o = (cnt_q != '0) ? mem_q[rd_q] : '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: issues word fetches, tracks in-flight reads by epoch, buffers
// results and hands {pc, inst} downstream; stops on the all-zero word.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter int          MEM_LATENCY = 1,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_read_address,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_read_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halt
);
  localparam int LAST = MEM_LATENCY - 1;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic epoch_q, epoch_d, halted_q, halted_d;
  trk_stage_t trk_q [MEM_LATENCY];
  trk_stage_t trk_d [MEM_LATENCY];
  logic [$clog2(DEPTH):0] fifo_count;
  fetch_entry_t head;
  int inflight;
  logic resp_ok, stop_hit, push, issue, kill;
  always_comb begin
    inflight = 0;
    for (int k = 0; k < MEM_LATENCY; k++) inflight += int'(trk_q[k].vld);
    resp_ok = trk_q[LAST].vld && (trk_q[LAST].ep == epoch_q);
    stop_hit = resp_ok && (mem_read_data == INST_STOP);
    push = resp_ok && !stop_hit && !redirect_valid;
    // credit check counts buffered plus in-flight words so a push never finds the FIFO full
    issue = !halted_q && !stop_hit && !redirect_valid && (int'(fifo_count) + inflight < DEPTH);
    kill = redirect_valid || stop_hit;
    epoch_d = epoch_q ^ kill;
    halted_d = !redirect_valid && (halted_q || stop_hit);
    fetch_pc_d = redirect_valid ? (redirect_pc & ~32'h3) : issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
    trk_d[0] = '{vld: issue, ep: epoch_q, pc: fetch_pc_q};
    for (int k = 1; k < MEM_LATENCY; k++) trk_d[k] = trk_q[k-1];
    for (int k = 0; k < MEM_LATENCY; k++) trk_d[k].vld = trk_d[k].vld && !kill;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      epoch_q <= 1'b0;
      halted_q <= 1'b0;
      trk_q <= '{default: '0};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      epoch_q <= epoch_d;
      halted_q <= halted_d;
      trk_q <= trk_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .entry_i ('{pc: trk_q[LAST].pc, inst: mem_read_data}),
    .pop_i   (inst_valid && inst_ready),
    .flush_i (redirect_valid),
    .count_o (fifo_count),
    .head_o  (head)
  );
  assign mem_read_address = fetch_pc_q;
  assign mem_funct3 = FUNCT3_WORD;
  assign inst_valid = fifo_count != '0;
  assign inst_data = head.inst;
  assign inst_pc = head.pc;
  assign halt = halted_q && (fifo_count == '0);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a program-order stream model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] mem_read_address, mem_read_data, inst_data, inst_pc;
  logic [31:0] redirect_pc = 32'h0;
  logic [2:0] mem_funct3;
  logic inst_valid, halt;
  logic inst_ready = 1'b0;
  logic redirect_valid = 1'b0;
  logic [31:0] mem_arr [64];
  int tests = 0, fails = 0, hs = 0;
  logic [31:0] exp_pc = 32'h0;
  logic pv = 1'b0, pr = 1'b0, prv = 1'b0;
  logic [31:0] ppc, pdat, got_pc, addr_snap;
  logic got_valid, got_halt;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(4), .MEM_LATENCY(1), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_read_address (mem_read_address),
    .mem_funct3       (mem_funct3),
    .mem_read_data    (mem_read_data),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst_data        (inst_data),
    .inst_pc          (inst_pc),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .halt             (halt)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return mem_arr[a[7:2]];
  endfunction

  always @(posedge clk) mem_read_data <= memf(mem_read_address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // one clock: sample at the falling edge, apply inputs, advance the program-order model
  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    if (pv && !pr && !prv) begin
      chk("hold_valid", 32'(inst_valid), 32'h1);
      chk("hold_pc", inst_pc, ppc);
      chk("hold_data", inst_data, pdat);
    end
    if (halt) chk("halt_only_at_stop", memf(exp_pc), 32'h0);
    inst_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    got_valid = inst_valid;
    got_pc = inst_pc;
    got_halt = halt;
    if (inst_valid && rdy) begin
      chk("stream_pc", inst_pc, exp_pc);
      chk("stream_data", inst_data, memf(exp_pc));
      exp_pc += 32'd4;
      hs++;
    end
    if (rv) exp_pc = rpc & ~32'h3;
    pv = inst_valid;
    pr = rdy;
    prv = rv;
    ppc = inst_pc;
    pdat = inst_data;
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst_n = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_halt", 32'(halt), 32'h0);
    chk("rst_addr", mem_read_address, 32'h0);
    chk("rst_funct3", 32'(mem_funct3), 32'h2);
    @(negedge clk);
    rst_n = 1'b1;
    inst_ready = rdy;
    exp_pc = 32'h0;
    pv = 1'b0;
    prv = 1'b0;
  endtask

  task automatic wait_valid(input logic rdy, input string tag);
    got_valid = 1'b0;
    for (int i = 0; i < 12 && !got_valid; i++) cycle(rdy, 1'b0, 32'h0);
    chk(tag, 32'(got_valid), 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_arr[i] = $urandom | 32'h1;
    // program ending in a stop word
    mem_arr[0] = 32'h0050_0093;
    mem_arr[1] = 32'h0010_8113;
    mem_arr[2] = 32'h0;
    do_reset(1'b1);
    cycle(1'b1, 1'b0, 32'h0);
    chk("lat_no_bypass", 32'(got_valid), 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    chk("lat_valid", 32'(got_valid), 32'h1);
    chk("lat_first_pc", got_pc, 32'h0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0);
    chk("stop_halt", 32'(got_halt), 32'h1);
    chk("stop_no_valid", 32'(got_valid), 32'h0);
    addr_snap = mem_read_address;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0);
    chk("stop_addr_frozen", mem_read_address, addr_snap);
    chk("stop_halt_held", 32'(halt), 32'h1);

    // backpressure fills exactly DEPTH entries
    mem_arr[2] = $urandom | 32'h1;
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 32'h0);
    chk("bp_addr", mem_read_address, 32'h10);
    chk("bp_head_pc", inst_pc, 32'h0);
    hs = 0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0);
    chk("bp_drained", 32'(hs >= 4), 32'h1);

    // redirect with 2 buffered and 1 in flight
    do_reset(1'b0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h43);
    wait_valid(1'b0, "redir_valid");
    chk("redir_pc", got_pc, 32'h40);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);

    // redirect coinciding with a head handshake; 0x88 is a stop word
    mem_arr[34] = 32'h0;
    cycle(1'b1, 1'b1, 32'h80);
    wait_valid(1'b0, "hs_redir_valid");
    chk("hs_redir_pc", got_pc, 32'h80);
    got_halt = 1'b0;
    for (int i = 0; i < 20 && !got_halt; i++) cycle(1'b1, 1'b0, 32'h0);
    chk("halt_reached", 32'(got_halt), 32'h1);
    cycle(1'b1, 1'b1, 32'h100);
    cycle(1'b1, 1'b0, 32'h0);
    chk("halt_falls", 32'(got_halt), 32'h0);
    wait_valid(1'b0, "resume_valid");
    chk("resume_pc", got_pc, 32'h100);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0);

    // pc wraps past the top of the address space
    cycle(1'b1, 1'b1, 32'hFFFF_FFF7);
    wait_valid(1'b0, "wrap_valid");
    chk("wrap_pc", got_pc, 32'hFFFF_FFF4);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0);

    // asynchronous reset between clock edges
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(inst_valid), 32'h0);
    chk("async_addr", mem_read_address, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    exp_pc = 32'h0;
    pv = 1'b0;
    prv = 1'b0;
    wait_valid(1'b1, "async_restart_valid");
    chk("async_restart_pc", got_pc, 32'h0);

    // random stream with stop words, backpressure and redirects
    for (int i = 0; i < 64; i++) mem_arr[i] = ($urandom_range(0, 11) == 0) ? 32'h0 : ($urandom | 32'h1);
    do_reset(1'b1);
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 23) == 0, $urandom);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the decode/execute controller. It generates word addresses into the instruction memory and absorbs the memory's fixed read latency. It buffers fetched words in a small FIFO and hands {pc, instruction} to the controller over a valid/ready handshake. It also handles control-flow redirects from the controller and detects the all-zero stop word.

Parameters:
DEPTH, 4, instruction FIFO entries; power of 2, minimum 2.
MEM_LATENCY, 1, cycles from address presented to mem_read_data valid; minimum 1.
RESET_PC, 32'h0000_0000, first fetch address after reset; word aligned.

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  reset; asynchronous, active-low.
mem_read_address  out  32  instruction word address; register output.
mem_funct3  out  3  constant 3'b010 (full-word read).
mem_read_data  in  32  instruction word; valid MEM_LATENCY cycles after its address.
inst_valid  out  1  FIFO head holds an instruction.
inst_ready  in  1  controller accepts the head this cycle.
inst_data  out  32  head instruction.
inst_pc  out  32  address of the head instruction.
redirect_valid  in  1  controller requests a fetch restart (taken branch, JAL/JALR).
redirect_pc  in  32  new fetch address.
halt  out  1  stop word reached and FIFO drained.

Behaviour:
- Reset (async assert, rst_n low):
  - fetch_pc = RESET_PC and mem_read_address = RESET_PC.
  - FIFO empty, so inst_valid = 0; inst_data and inst_pc = 0.
  - In-flight tracker cleared, epoch = 0, halted = 0, halt = 0.
- Issue: a request issues in cycle N when all of these hold:
  - !halted and !redirect_valid;
  - fifo_count + inflight_count < DEPTH (credit check).
  - On issue: fetch_pc += 4 and mem_read_address follows fetch_pc. The credit check guarantees a push never meets a full FIFO.
- In-flight tracker: a shift register of MEM_LATENCY stages, each holding {valid, epoch, pc}.
  - A response is captured in cycle N+MEM_LATENCY.
  - It is pushed only if its stage is valid and its epoch equals the current epoch; otherwise it is dropped silently.
- Latency: issue in cycle N, response in N+1, inst_valid in N+2 (MEM_LATENCY=1). There is no bypass from an empty FIFO.
- Handshake:
  - The head transfers when inst_valid && inst_ready.
  - inst_data and inst_pc are held stable while inst_valid && !inst_ready.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
- Stop word: a current-epoch response equal to 32'h0 is not pushed.
  - halted is set and epoch toggles, which drops younger in-flight words.
  - Issue stops.
  - halt = halted && FIFO empty.
- Redirect (redirect_valid=1 in cycle N):
  - Takes priority over push and issue.
  - FIFO flushed (count = 0 at N+1).
  - epoch toggles and halted clears.
  - fetch_pc = redirect_pc & ~32'h3.
  - A handshake in cycle N still completes (the consumer owns that word).
  - No issue in cycle N; the first new issue is at N+1.
  - Back-to-back redirects: the last one wins.
- Arithmetic: fetch_pc wraps modulo 2^32, so 0xFFFF_FFFC + 4 = 0. Pointers wrap modulo DEPTH. Count width is $clog2(DEPTH)+1.
- mem_funct3 is constant, including during reset.

Decomposition:
- fetch_pkg:
  - FUNCT3_WORD = 3'b010;
  - INST_STOP = 32'h0;
  - typedef struct packed {logic [31:0] pc; logic [31:0] inst;} fetch_entry_t.
- Sub-module fetch_fifo (DEPTH, fetch_entry_t payload):
  - ports: push, pop, flush, count, head;
  - same async active-low reset.

Test Plan:
1. Memory[0x0,0x4,0x8] = 0x00500093, 0x00108113, 0x0; inst_ready=1 -> inst_valid 2 cycles after first issue with pc 0x0/0x00500093, then pc 0x4/0x00108113; word 0x8 is never presented; halt=1 once drained; issue stops with no further addresses fetched.
2. Straight-line code, inst_ready=0 for 12 cycles -> exactly 4 entries, mem_read_address frozen at 0x10; release -> pcs 0x0, 0x4, 0x8, 0xC in order, none lost or duplicated.
3. Redirect to 0x43 while 2 entries are buffered and 1 is in flight -> next inst_pc = 0x40; the stale in-flight word is dropped; no old-pc entry appears.
4. redirect_valid and a head handshake in the same cycle -> the head is consumed exactly once; the next valid entry is the redirect target.
5. Redirect to 0x100 while halt=1 -> halt falls, fetching resumes, inst_pc 0x100, 0x104.
6. rst_n dropped mid-stream between clock edges -> inst_valid=0 and mem_read_address=RESET_PC immediately, without waiting for a clock edge; after release, fetch restarts from RESET_PC.
